// File: rtl/envelope_mult.sv
// Sequential shift-add multiplier scaling a signed waveform sample by an unsigned
// envelope level, one envelope bit per clock, with a start/ready handshake.
module envelope_mult #(
  parameter int WAVE_W = 12,
  parameter int ENV_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [WAVE_W-1:0] wave_i,
  input  logic [ENV_W-1:0]  env_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic [WAVE_W-1:0] product_o,
  output logic [1:0]        dbg_state_o
);

  localparam int ACC_W = WAVE_W + ENV_W;
  localparam int CNT_W = (ENV_W > 1) ? $clog2(ENV_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Handshake: start_i is a request sampled only in S_IDLE; ready_o is a
  // registered one-cycle pulse marking product_o as freshly valid.
  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, mcand_q, acc_sum;
  logic [ENV_W-1:0]  sreg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_iter;

  assign acc_sum   = sreg_q[0] ? acc_q + mcand_q : acc_q;
  assign last_iter = (state_q == S_MUL) && (cnt_q == CNT_W'(ENV_W - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_LOAD;
      S_LOAD:  state_d = S_MUL;
      S_MUL:   if (last_iter) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      sreg_q    <= '0;
      cnt_q     <= '0;
      product_o <= '0;
      ready_o   <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      case (state_q)
        S_LOAD: begin
          acc_q   <= '0;
          mcand_q <= {{ENV_W{wave_i[WAVE_W-1]}}, wave_i};
          sreg_q  <= env_i;
          cnt_q   <= '0;
        end
        S_MUL: begin
          acc_q   <= acc_sum;
          mcand_q <= mcand_q << 1;
          sreg_q  <= sreg_q >> 1;
          cnt_q   <= cnt_q + CNT_W'(1);
          // The product is latched on the edge entering DONE so it is valid for
          // the whole DONE cycle alongside ready_o; the upper slice is the floor.
          if (last_iter) begin
            product_o <= acc_sum[ACC_W-1:ENV_W];
            ready_o   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_envelope_mult.sv
// Bench for envelope_mult: directed corner cases plus randomized operands,
// scored against an arithmetic floor((wave*env)/256) reference.
module tb_envelope_mult;

  localparam int WAVE_W = 12;
  localparam int ENV_W  = 8;

  logic              clk_i;
  logic              rst_ni;
  logic              start_i;
  logic [WAVE_W-1:0] wave_i;
  logic [ENV_W-1:0]  env_i;
  logic              ready_o;
  logic              busy_o;
  logic [WAVE_W-1:0] product_o;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int ready_cnt = 0;
  logic [WAVE_W-1:0] exp_q[$];

  envelope_mult #(.WAVE_W(WAVE_W), .ENV_W(ENV_W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .wave_i      (wave_i),
    .env_i       (env_i),
    .ready_o     (ready_o),
    .busy_o      (busy_o),
    .product_o   (product_o),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference: signed product, then floor division by 2^ENV_W.
  function automatic logic [WAVE_W-1:0] model(input logic [WAVE_W-1:0] w, input logic [ENV_W-1:0] e);
    int p, q;
    p = int'($signed(w)) * int'({1'b0, e});
    q = p / 256;
    if (p < 0 && (p % 256) != 0) q = q - 1;
    return q[WAVE_W-1:0];
  endfunction

  // scoreboard: every ready pulse consumes one expected product
  always @(negedge clk_i) begin
    if (rst_ni && ready_o) begin
      ready_cnt++;
      if (exp_q.size() == 0) check("unexpected_ready", ready_o, 1'b0);
      else check("product", product_o, exp_q.pop_front());
    end
  end

  // driver: one handshake; env_e is on the start cycle, env_l from the LOAD cycle on
  task automatic run_op(input logic [WAVE_W-1:0] w, input logic [ENV_W-1:0] env_e,
                        input logic [ENV_W-1:0] env_l, input bit disturb);
    int lat;
    exp_q.push_back(model(w, env_l));
    @(negedge clk_i);
    start_i = 1'b1; wave_i = w; env_i = env_e;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0; env_i = env_l;
    lat = 0;
    while (!ready_o && lat < 20) begin
      @(negedge clk_i);
      lat++;
      if (disturb && lat == 3) begin
        wave_i = WAVE_W'($urandom);
        env_i  = ENV_W'($urandom);
      end
    end
    check("latency", lat, 9);
    @(negedge clk_i);
    check("ready_one_cycle", ready_o, 1'b0);
    check("idle_after_done", busy_o, 1'b0);
  endtask

  initial begin
    int base, k;
    int times[$];
    logic [WAVE_W-1:0] w;
    logic [ENV_W-1:0]  e;

    rst_ni = 1'b0; start_i = 1'b0; wave_i = '0; env_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst_product", product_o, 0);
    check("rst_ready", ready_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    check("idle_product", product_o, 0);
    check("idle_busy", busy_o, 1'b0);

    // directed corner values
    run_op(12'h7FF, 8'hFF, 8'hFF, 1'b0);
    check("max_pos_direct", product_o, 12'h7F7);
    run_op(12'h800, 8'hFF, 8'hFF, 1'b0);
    check("max_neg_direct", product_o, 12'h808);
    run_op(12'hFFF, 8'h01, 8'h01, 1'b0);
    check("minus_one_floor", product_o, 12'hFFF);
    run_op(12'h5A5, 8'h00, 8'h00, 1'b0);
    check("env_zero", product_o, 12'h000);
    run_op(12'h400, 8'h80, 8'h80, 1'b0);
    check("half_scale", product_o, 12'h200);

    // operands captured in LOAD, later changes ignored
    run_op(12'h100, 8'h10, 8'h40, 1'b0);
    check("capture_in_load", product_o, 12'h040);
    run_op(12'h100, 8'h10, 8'h40, 1'b1);
    check("mul_inputs_ignored", product_o, 12'h040);

    // start pulses during MUL and DONE are not queued
    base = ready_cnt;
    exp_q.push_back(model(12'h123, 8'h77));
    @(negedge clk_i);
    start_i = 1'b1; wave_i = 12'h123; env_i = 8'h77;
    @(posedge clk_i);
    for (k = 0; k < 26; k++) begin
      @(negedge clk_i);
      start_i = (k == 4) || (k == 9);
    end
    check("no_extra_ready", ready_cnt - base, 1);
    check("idle_after_pulses", busy_o, 1'b0);

    // start held high: accepted once per IDLE visit
    base = ready_cnt;
    repeat (4) exp_q.push_back(model(12'h7FF, 8'hFF));
    @(negedge clk_i);
    start_i = 1'b1; wave_i = 12'h7FF; env_i = 8'hFF;
    @(posedge clk_i);
    for (k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (ready_o) times.push_back(k);
    end
    start_i = 1'b0;
    check("held_pulses_in_40", times.size(), 3);
    if (times.size() == 3) begin
      check("held_first_at", times[0], 9);
      check("held_spacing_a", times[1] - times[0], 11);
      check("held_spacing_b", times[2] - times[1], 11);
    end
    repeat (15) @(negedge clk_i);
    check("held_total_pulses", ready_cnt - base, 4);

    // reset in the middle of MUL aborts the operation
    base = ready_cnt;
    @(negedge clk_i);
    start_i = 1'b1; wave_i = 12'h333; env_i = 8'hC3;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (4) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    exp_q.delete();
    check("abort_product", product_o, 0);
    check("abort_busy", busy_o, 1'b0);
    check("abort_ready", ready_o, 1'b0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (12) @(negedge clk_i);
    check("abort_no_ready", ready_cnt - base, 0);
    run_op(12'h333, 8'hC3, 8'hC3, 1'b0);
    check("after_abort", product_o, model(12'h333, 8'hC3));

    // randomized operand pairs
    for (int i = 0; i < 1100; i++) begin
      w = WAVE_W'($urandom);
      e = ENV_W'($urandom_range(0, 255));
      run_op(w, e, e, (i % 4) == 0);
    end
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/envelope_mult.md
# envelope_mult

Sequential shift-add multiplier that applies the 8-bit envelope level to a voice waveform sample. It is the responder side of the envelope generator's multiply handshake. It sits between the per-voice waveform/envelope path and the voice mixer. It accepts a one-cycle start request, captures the waveform sample and the updated envelope level, and iterates one envelope bit per clock. It then returns a scaled signed sample with a one-cycle ready pulse.

## Interface
Parameters:
- WAVE_W, 12, waveform sample width (two's complement)
- ENV_W, 8, envelope level width (unsigned); also the iteration count

Ports:
- clk_i  input  1  system clock, all state on rising edge
- rst_ni  input  1  reset; asynchronous, active-low
- start_i  input  1  multiply request (envelope's mult_start), sampled only in IDLE
- wave_i  input  WAVE_W  signed waveform sample of the active voice
- env_i  input  ENV_W  unsigned envelope level of the active voice (envelope's env_raw_o)
- ready_o  output  1  one-cycle pulse: product_o valid and updated (envelope's mult_ready)
- busy_o  output  1  high in LOAD, MUL and DONE
- product_o  output  WAVE_W  signed result, floor((wave × env) / 2^ENV_W), held until the next DONE

## Operation
- FSM states: IDLE, LOAD, MUL, DONE.
- IDLE: if start_i is high, go to LOAD. Otherwise stay in IDLE.
- LOAD: capture operands, clear accumulator and bit counter, then go to MUL.
  - wave_i is captured sign-extended into a WAVE_W+ENV_W multiplicand.
  - env_i is captured into a shift register.
  - Operands are deliberately captured one cycle after start, so env_i reflects the volume the envelope wrote on the start edge.
- MUL, one iteration per cycle, ENV_W iterations:
  - If the shift-register LSB is 1, acc += multiplicand.
  - Then multiplicand <<= 1, shift register >>= 1, counter++.
  - When the counter reaches ENV_W-1 and that iteration completes, go to DONE.
- DONE: product_o <= acc[WAVE_W+ENV_W-1:ENV_W] (arithmetic floor), ready_o = 1, then go to IDLE.
- Arithmetic and width rules:
  - Accumulator is WAVE_W+ENV_W bits, signed.
  - No overflow is possible, because |wave × env| < 2^(WAVE_W+ENV_W-1).
  - No saturation logic.
  - Result is truncated (floor), not rounded. Negative values round toward −inf: −1 × 1 gives −1.
- start_i while busy_o is high is ignored; it is not queued.
- wave_i and env_i changes after LOAD do not affect the running product.
- env_i = 0 gives product 0 for any wave. MUL still runs its full ENV_W cycles, so latency is constant.
- product_o updates only in DONE; it is stable at every other time.

## Timing
- Reset (async assert) forces:
  - state = IDLE, ready_o = 0, busy_o = 0, product_o = 0;
  - acc, multiplicand, shift register and counter = 0.
- Reset release is synchronous to clk_i. The first start_i is honoured on the first edge after release.
- Latency, with start_i high at edge E0:
  - LOAD during cycle E0→E1; operands captured at E1.
  - MUL for edges E1..E8 (8 iterations).
  - DONE during cycle E9→E10: ready_o high and product_o valid from E9.
  - Total: ready_o is high for the cycle starting at E0+ENV_W+1 (E9 for ENV_W = 8).
- ready_o is high for exactly one cycle per accepted start and is registered (no combinational path from inputs).
- busy_o is combinational from state.
- Back-to-back operation:
  - start_i high in the cycle right after DONE (state IDLE) is accepted.
  - The minimum start-to-start interval is ENV_W+3 cycles.
- Reset asserted mid-MUL aborts the operation immediately: no ready_o pulse, and product_o returns to 0.
- start_i held high continuously: accepted once per IDLE visit, i.e. every ENV_W+3 cycles.

## Test plan
- Reset, then idle: product_o = 0, ready_o = 0, busy_o = 0. Then start with wave = 0x7FF, env = 0xFF → ready_o pulses at E9 with product_o = 0x7F7 (2039).
- wave = 0x800 (−2048), env = 0xFF → product_o = −2040 (0x808). Then wave = 0xFFF (−1), env = 0x01 → product_o = 0xFFF (−1).
- env = 0x00, wave = 0x5A5 → product_o = 0 after the same 9-cycle latency. Then env = 0x80, wave = 0x400 → product_o = 0x200.
- Operand capture: drive env_i = 0x10 on the start cycle and env_i = 0x40 on the next cycle, with wave = 0x100. Required product_o = 0x040, proving capture happens in LOAD. Then change wave_i and env_i during MUL: result is unchanged.
- Pulse start_i during MUL and during DONE: no extra ready_o. Hold start_i high for 40 cycles: exactly 3 ready_o pulses, spaced 11 cycles apart.
- Assert rst_ni low at MUL iteration 4: product_o = 0, busy_o = 0, no ready_o. After release, a new start yields the correct result.
- Randomised check against floor((wave × env)/256) for more than 1000 operand pairs, driven by a model of the envelope handshake (start pulse, wait for ready).
